operand_fetch_unit: RTL and testbench

- Initiator/client side of the CPU register bank.
- Accepts decoded instructions over a valid/ready handshake and drives the bank's two read selects. Captures operands and presents them to execute over a second valid/ready handshake.
- Accepts writebacks from execute and drives the bank's write port.
- A per-register scoreboard stalls read-after-write and write-after-write hazards.

---
 rtl/operand_fetch_unit_if.sv | 47 ++++
 rtl/operand_fetch_unit.sv | 135 +++++++++++++
 tb/tb_operand_fetch_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_unit_if.sv
// Bundle between the operand fetch unit and its environment: decode, register
// bank read/write ports, execute handoff and writeback.
interface operand_fetch_unit_if #(
  parameter int SEL_W = 5
);
  // decode handshake
  logic             dec_valid;
  logic             dec_ready;
  logic [SEL_W-1:0] dec_rn;
  logic [SEL_W-1:0] dec_rm;
  logic [SEL_W-1:0] dec_rd;
  logic             dec_use_rn;
  logic             dec_use_rm;
  logic             dec_wr_rd;
  // register bank
  logic [SEL_W-1:0] rf_read_sel_1;
  logic [SEL_W-1:0] rf_read_sel_2;
  logic [31:0]      rf_read_data_1;
  logic [31:0]      rf_read_data_2;
  logic             rf_write;
  logic [SEL_W-1:0] rf_write_sel;
  logic [31:0]      rf_write_data;
  // execute handoff and writeback
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      ex_op_a;
  logic [31:0]      ex_op_b;
  logic [SEL_W-1:0] ex_rd;
  logic             ex_wr_rd;
  logic             wb_valid;
  logic [SEL_W-1:0] wb_rd;
  logic [31:0]      wb_data;

  modport master (
    input  dec_valid, dec_rn, dec_rm, dec_rd, dec_use_rn, dec_use_rm, dec_wr_rd,
    input  rf_read_data_1, rf_read_data_2, ex_ready, wb_valid, wb_rd, wb_data,
    output dec_ready, rf_read_sel_1, rf_read_sel_2, rf_write, rf_write_sel,
    output rf_write_data, ex_valid, ex_op_a, ex_op_b, ex_rd, ex_wr_rd
  );

  modport slave (
    output dec_valid, dec_rn, dec_rm, dec_rd, dec_use_rn, dec_use_rm, dec_wr_rd,
    output rf_read_data_1, rf_read_data_2, ex_ready, wb_valid, wb_rd, wb_data,
    input  dec_ready, rf_read_sel_1, rf_read_sel_2, rf_write, rf_write_sel,
    input  rf_write_data, ex_valid, ex_op_a, ex_op_b, ex_rd, ex_wr_rd
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// Operand fetch: decode -> bank read -> execute handoff, with a per-register
// pending scoreboard. Define WB_BYPASS_EN to forward the in-flight writeback.
module operand_fetch_unit #(
  parameter int NREGS = 32,
  parameter int SEL_W = 5
) (
  input logic                  clk,
  input logic                  reset,
  operand_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, OUT} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel1_q, sel2_q, rd_q, ex_rd_q, wsel_q;
  logic             use_rn_q, use_rm_q, wr_rd_q, ex_wr_rd_q, wr_q;
  logic [31:0]      op_a_q, op_b_q, wdata_q, op_a_d, op_b_d;
  logic [NREGS-1:0] pend_q, pend_d, pend_eff;
  logic             hazard, dec_fire, ex_fire;

  // Selects beyond the bank depth never count as pending.
  function automatic logic in_range(input logic [SEL_W-1:0] s);
    return int'(s) < NREGS;
  endfunction

  function automatic logic pend_bit(input logic [NREGS-1:0] v, input logic [SEL_W-1:0] s);
    return in_range(s) && v[s];
  endfunction

  always_comb begin
    pend_eff = pend_q;
`ifdef WB_BYPASS_EN
    if (wr_q && in_range(wsel_q)) pend_eff[wsel_q] = 1'b0;
`endif
  end

  assign hazard = (bus.dec_use_rn & pend_bit(pend_eff, bus.dec_rn)) |
                  (bus.dec_use_rm & pend_bit(pend_eff, bus.dec_rm)) |
                  (bus.dec_wr_rd  & pend_bit(pend_eff, bus.dec_rd));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.dec_ready = 1'b0;
    bus.ex_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.dec_ready = !hazard && !reset;
        if (bus.dec_valid && bus.dec_ready) state_d = READ;
      end
      READ: state_d = OUT;
      OUT: begin
        bus.ex_valid = 1'b1;
        if (bus.ex_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dec_fire = (state_q == IDLE) && bus.dec_valid && bus.dec_ready;
  assign ex_fire  = (state_q == OUT) && bus.ex_ready;

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    if (use_rn_q) op_a_d = bus.rf_read_data_1;
    if (use_rm_q) op_b_d = bus.rf_read_data_2;
`ifdef WB_BYPASS_EN
    if (use_rn_q && wr_q && wsel_q == sel1_q) op_a_d = wdata_q;
    if (use_rm_q && wr_q && wsel_q == sel2_q) op_b_d = wdata_q;
`endif
  end

  // Set after clear: a retiring writer's set outranks an older writeback's clear.
  always_comb begin
    pend_d = pend_q;
    if (wr_q && in_range(wsel_q)) pend_d[wsel_q] = 1'b0;
    if (ex_fire && ex_wr_rd_q && in_range(ex_rd_q)) pend_d[ex_rd_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel1_q     <= '0;
      sel2_q     <= '0;
      rd_q       <= '0;
      use_rn_q   <= 1'b0;
      use_rm_q   <= 1'b0;
      wr_rd_q    <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      ex_rd_q    <= '0;
      ex_wr_rd_q <= 1'b0;
      wr_q       <= 1'b0;
      wsel_q     <= '0;
      wdata_q    <= '0;
      pend_q     <= '0;
    end else begin
      if (dec_fire) begin
        sel1_q   <= bus.dec_rn;
        sel2_q   <= bus.dec_rm;
        rd_q     <= bus.dec_rd;
        use_rn_q <= bus.dec_use_rn;
        use_rm_q <= bus.dec_use_rm;
        wr_rd_q  <= bus.dec_wr_rd;
      end
      if (state_q == READ) begin
        op_a_q     <= op_a_d;
        op_b_q     <= op_b_d;
        ex_rd_q    <= rd_q;
        ex_wr_rd_q <= wr_rd_q;
      end
      wr_q <= bus.wb_valid;
      if (bus.wb_valid) begin
        wsel_q  <= bus.wb_rd;
        wdata_q <= bus.wb_data;
      end
      pend_q <= pend_d;
    end
  end

  assign bus.rf_read_sel_1 = sel1_q;
  assign bus.rf_read_sel_2 = sel2_q;
  assign bus.ex_op_a       = op_a_q;
  assign bus.ex_op_b       = op_b_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_wr_rd      = ex_wr_rd_q;
  assign bus.rf_write      = wr_q;
  assign bus.rf_write_sel  = wsel_q;
  assign bus.rf_write_data = wdata_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed + randomized bench for operand_fetch_unit; the bench owns the
// register bank and a reference model of register contents and pending set.
module tb_operand_fetch_unit;
  localparam int NREGS = 32;
  localparam int SEL_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_unit_if #(.SEL_W(SEL_W)) bus();
  operand_fetch_unit #(.NREGS(NREGS), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Environment: the register bank itself.
  logic [31:0] bank [NREGS];
  always @(posedge clk) if (bus.rf_write) bank[bus.rf_write_sel] <= bus.rf_write_data;
  assign bus.rf_read_data_1 = bank[bus.rf_read_sel_1];
  assign bus.rf_read_data_2 = bank[bus.rf_read_sel_2];

  // Reference model: architectural values and the set of registers awaiting writeback.
  logic [31:0]      mbank [NREGS];
  bit               mpend [NREGS];
  logic [SEL_W-1:0] wq_r[$];
  logic [31:0]      wq_d[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_dec(input logic [SEL_W-1:0] rn, rm, rd, input bit urn, urm, wr);
    bus.dec_rn = rn; bus.dec_rm = rm; bus.dec_rd = rd;
    bus.dec_use_rn = urn; bus.dec_use_rm = urm; bus.dec_wr_rd = wr;
  endtask

  task automatic probe(input logic [SEL_W-1:0] r, input bit pending, input string tag);
    bus.dec_valid = 1'b0;
    set_dec(r, '0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk(tag, 32'(bus.dec_ready), 32'(!pending));
  endtask

  // Issue the queued writebacks back-to-back and check each write pulse.
  task automatic wb_flush();
    int n;
    n = wq_r.size();
    if (n == 0) return;
    bus.wb_valid = 1'b1; bus.wb_rd = wq_r[0]; bus.wb_data = wq_d[0];
    for (int i = 0; i < n; i++) begin
      tick();
      chk("wb_pulse", 32'(bus.rf_write), 32'd1);
      chk("wb_sel", 32'(bus.rf_write_sel), 32'(wq_r[i]));
      chk("wb_data", bus.rf_write_data, wq_d[i]);
      mbank[wq_r[i]] = wq_d[i];
      mpend[wq_r[i]] = 1'b0;
      if (i + 1 < n) begin
        bus.wb_rd = wq_r[i+1]; bus.wb_data = wq_d[i+1];
      end else bus.wb_valid = 1'b0;
    end
    tick();
    chk("wb_idle", 32'(bus.rf_write), 32'd0);
    wq_r.delete(); wq_d.delete();
  endtask

  task automatic start_instr(input logic [SEL_W-1:0] rn, rm, rd, input bit urn, urm, wr,
                             input logic [31:0] ea, eb);
    set_dec(rn, rm, rd, urn, urm, wr);
    bus.dec_valid = 1'b1;
    #1;
    chk("issue_ready", 32'(bus.dec_ready), 32'd1);
    tick();
    bus.dec_valid = 1'b0;
    chk("read_sel1", 32'(bus.rf_read_sel_1), 32'(rn));
    chk("read_sel2", 32'(bus.rf_read_sel_2), 32'(rm));
    chk("read_exv", 32'(bus.ex_valid), 32'd0);
    chk("read_decr", 32'(bus.dec_ready), 32'd0);
    tick();
    chk("latency_exv", 32'(bus.ex_valid), 32'd1);
    chk("op_a", bus.ex_op_a, ea);
    chk("op_b", bus.ex_op_b, eb);
    chk("ex_rd", 32'(bus.ex_rd), 32'(rd));
    chk("ex_wr_rd", 32'(bus.ex_wr_rd), 32'(wr));
  endtask

  task automatic hold_chk(input int n, input logic [31:0] ea, eb);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("hold_exv", 32'(bus.ex_valid), 32'd1);
      chk("hold_op_a", bus.ex_op_a, ea);
      chk("hold_op_b", bus.ex_op_b, eb);
      chk("hold_decr", 32'(bus.dec_ready), 32'd0);
    end
  endtask

  task automatic accept(input bit wr, input logic [SEL_W-1:0] rd);
    bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0;
    chk("post_acc_exv", 32'(bus.ex_valid), 32'd0);
    if (wr) mpend[rd] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEL_W-1:0] rn, rm, rd;
    bit urn, urm, wr, haz;
    logic [31:0] ea, eb;

    reset = 1'b1;
    bus.dec_valid = 1'b0; bus.ex_ready = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    set_dec('0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NREGS; i++) mpend[i] = 1'b0;
    tick(); tick(); #1;
    chk("rst_exv", 32'(bus.ex_valid), 32'd0);
    chk("rst_decr", 32'(bus.dec_ready), 32'd0);
    chk("rst_wr", 32'(bus.rf_write), 32'd0);
    chk("rst_sel1", 32'(bus.rf_read_sel_1), 32'd0);
    chk("rst_op_a", bus.ex_op_a, 32'd0);
    tick();
    reset = 1'b0;
    probe(5'd0, 1'b0, "rst_release_ready");

    // Preload every register through the write port, back-to-back.
    for (int i = 0; i < NREGS; i++) begin
      wq_r.push_back(SEL_W'(i));
      wq_d.push_back(i == 3 ? 32'h11 : i == 4 ? 32'h22 : i == 7 ? 32'hFF : $urandom);
    end
    wb_flush();

    // Basic read and unused operand.
    start_instr(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22);
    accept(1'b1, 5'd5);
    probe(5'd5, 1'b1, "pend5_set");
    start_instr(5'd3, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0);
    accept(1'b0, 5'd0);

    // RAW stall released by a writeback.
    probe(5'd5, 1'b1, "raw_stall");
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hABCD;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("raw_pulse", 32'(bus.rf_write), 32'd1);
    chk("raw_pulse_sel", 32'(bus.rf_write_sel), 32'd5);
`ifdef WB_BYPASS_EN
    chk("raw_ready_in_pulse", 32'(bus.dec_ready), 32'd1);
`else
    chk("raw_ready_in_pulse", 32'(bus.dec_ready), 32'd0);
`endif
    tick(); #1;
    chk("raw_pulse_end", 32'(bus.rf_write), 32'd0);
    chk("raw_ready_after", 32'(bus.dec_ready), 32'd1);
    mbank[5] = 32'hABCD; mpend[5] = 1'b0;
    start_instr(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'hABCD, 32'h0);
    accept(1'b0, 5'd6);

    // Back-pressure.
    start_instr(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 32'h11, 32'h22);
    hold_chk(4, 32'h11, 32'h22);
    accept(1'b1, 5'd9);
    probe(5'd9, 1'b1, "bp_pend9");
    wq_r.push_back(5'd9); wq_d.push_back($urandom);
    wb_flush();
    probe(5'd9, 1'b0, "bp_pend9_clear");

    // Writeback clear of r2 lands on the same edge as a new r2 writer retiring.
    start_instr(5'd4, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 32'h22, 32'h11);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h77;
    tick();
    bus.wb_valid = 1'b0;
    chk("coll_pulse", 32'(bus.rf_write), 32'd1);
    accept(1'b1, 5'd2);
    mbank[2] = 32'h77;
    probe(5'd2, 1'b1, "coll_set_wins");
    wq_r.push_back(5'd2); wq_d.push_back($urandom);
    wb_flush();

    // Randomized instruction stream against the model.
    for (int it = 0; it < 40; it++) begin
      rn = SEL_W'($urandom); rm = SEL_W'($urandom); rd = SEL_W'($urandom);
      urn = 1'($urandom); urm = 1'($urandom); wr = 1'($urandom);
      haz = (urn && mpend[rn]) || (urm && mpend[rm]) || (wr && mpend[rd]);
      bus.dec_valid = 1'b0;
      set_dec(rn, rm, rd, urn, urm, wr);
      #1;
      chk("rand_hazard", 32'(bus.dec_ready), 32'(!haz));
      if (urn && mpend[rn]) begin wq_r.push_back(rn); wq_d.push_back($urandom); end
      if (urm && mpend[rm]) begin wq_r.push_back(rm); wq_d.push_back($urandom); end
      if (wr && mpend[rd]) begin wq_r.push_back(rd); wq_d.push_back($urandom); end
      if ($urandom_range(0, 3) == 0) begin
        wq_r.push_back(SEL_W'($urandom)); wq_d.push_back($urandom);
      end
      wb_flush();
      ea = urn ? mbank[rn] : 32'h0;
      eb = urm ? mbank[rm] : 32'h0;
      start_instr(rn, rm, rd, urn, urm, wr, ea, eb);
      hold_chk($urandom_range(0, 2), ea, eb);
      accept(wr, rd);
    end

    // Asynchronous reset while an instruction sits in OUT with r6 pending.
    for (int i = 0; i < NREGS; i++)
      if (mpend[i]) begin wq_r.push_back(SEL_W'(i)); wq_d.push_back($urandom); end
    wb_flush();
    start_instr(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, mbank[1], mbank[2]);
    accept(1'b1, 5'd6);
    start_instr(5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 1'b1, mbank[3], mbank[4]);
    #2;
    reset = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'hDEAD;
    #1;
    chk("arst_exv", 32'(bus.ex_valid), 32'd0);
    chk("arst_op_a", bus.ex_op_a, 32'd0);
    chk("arst_op_b", bus.ex_op_b, 32'd0);
    chk("arst_ex_rd", 32'(bus.ex_rd), 32'd0);
    chk("arst_sel1", 32'(bus.rf_read_sel_1), 32'd0);
    chk("arst_decr", 32'(bus.dec_ready), 32'd0);
    tick();
    reset = 1'b0;
    bus.wb_valid = 1'b0;
    #1;
    chk("arst_wb_dropped", 32'(bus.rf_write), 32'd0);
    for (int i = 0; i < NREGS; i++) mpend[i] = 1'b0;
    probe(5'd6, 1'b0, "arst_pend6_cleared");
    start_instr(5'd6, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, mbank[6], mbank[1]);
    accept(1'b1, 5'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
